// File: rtl/systolic_array_mat_mult_nxn.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_mat_mult_nxn
// Purpose  : Output-stationary NxN systolic matrix multiplier, C = A x B,
//            where A is N x K and B is K x N. The inner dimension is chosen at
//            run time, results can accumulate across operations (tiling of
//            K beyond K_MAX), and accumulation optionally saturates.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start/k_len/accumulate, ready, done - operation control
//            a_valid/a_ready/a_in - A column beats (a_in[i] = A[i][k])
//            b_valid/b_ready/b_in - B row beats    (b_in[j] = B[k][j])
//            c_valid/c_ready/c_out/c_row - C rows, presented 0..N-1
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_mat_mult_nxn #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_MAX      = 256,
    parameter int SATURATE   = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(K_MAX+1)-1:0]          k_len,
    input  logic                                accumulate,
    output logic                                ready,
    output logic                                done,
    input  logic                                a_valid,
    output logic                                a_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]        a_in,
    input  logic                                b_valid,
    output logic                                b_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]        b_in,
    output logic                                c_valid,
    input  logic                                c_ready,
    output logic [N-1:0][ACC_WIDTH-1:0]         c_out,
    output logic [$clog2(N)-1:0]                c_row
);

    localparam int c_kw = $clog2(K_MAX+1);
    localparam int c_rw = $clog2(N);
    localparam int c_dw = $clog2(2*N);

    localparam logic [c_kw-1:0]      c_k_max      = c_kw'(K_MAX);
    localparam logic [c_rw-1:0]      c_last_row   = c_rw'(N-1);
    localparam logic [c_dw-1:0]      c_drain_last = c_dw'(2*N-1);
    localparam logic [ACC_WIDTH-1:0] c_acc_max    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_acc_min    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_drain  = 2'd2;
    localparam logic [1:0] c_st_output = 2'd3;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_kw-1:0] r_k_len;
    logic [c_kw-1:0] r_beat;
    logic [c_kw-1:0] w_beat_inc;
    logic [c_kw-1:0] w_k_eff;
    logic [c_dw-1:0] r_drain_cnt;
    logic [c_rw-1:0] w_next_row;

    logic w_start_op;
    logic w_clear;
    logic w_accept;
    logic w_last_beat;
    logic w_drain_done;
    logic w_row_xfer;
    logic w_last_xfer;
    logic w_load_first;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = (w_k_eff == '0) ? c_st_drain : c_st_load;
                end
            end
            c_st_load: begin
                if (w_last_beat) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_drain_done) begin
                    w_state_next = c_st_output;
                end
            end
            c_st_output: begin
                if (w_last_xfer) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Control decode
    always_comb begin
        w_k_eff      = (k_len > c_k_max) ? c_k_max : k_len;
        w_beat_inc   = r_beat + c_kw'(1);
        w_next_row   = c_row + c_rw'(1);
        w_start_op   = (r_state == c_st_idle) && start;
        w_clear      = w_start_op && !accumulate;
        // A beat only moves when both operand streams offer one together.
        w_accept     = (r_state == c_st_load) && a_valid && b_valid;
        w_last_beat  = w_accept && (w_beat_inc == r_k_len);
        w_drain_done = (r_state == c_st_drain) && (r_drain_cnt == c_drain_last);
        w_row_xfer   = (r_state == c_st_output) && c_valid && c_ready;
        w_last_xfer  = w_row_xfer && (c_row == c_last_row);
        // The first OUTPUT cycle fetches row 0; c_valid then stays high
        // until the final row leaves, so this fires once per operation.
        w_load_first = (r_state == c_st_output) && !c_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_len     <= '0;
            r_beat      <= '0;
            r_drain_cnt <= '0;
            ready       <= 1'b1;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
        end else begin
            ready   <= (w_state_next == c_st_idle);
            a_ready <= (w_state_next == c_st_load);
            b_ready <= (w_state_next == c_st_load);
            if (w_start_op) begin
                r_k_len <= w_k_eff;
                r_beat  <= '0;
            end else if (w_accept) begin
                r_beat  <= w_beat_inc;
            end
            if (r_state == c_st_drain) begin
                r_drain_cnt <= r_drain_cnt + c_dw'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row i of A and column j of B are delayed by i / j cycles
    // behind a common capture stage. Idle cycles capture zeros so the
    // array only ever sees real operands or zero products.
    // ------------------------------------------------------------------
    logic [N-1:0][DATA_WIDTH-1:0] w_a_feed;
    logic [N-1:0][DATA_WIDTH-1:0] w_b_feed;

    genvar gi, gj;
    for (gi = 0; gi < N; gi++) begin : g_skew
        logic [DATA_WIDTH-1:0] r_a_sr [0:gi];
        logic [DATA_WIDTH-1:0] r_b_sr [0:gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= gi; d++) begin
                    r_a_sr[d] <= '0;
                    r_b_sr[d] <= '0;
                end
            end else begin
                r_a_sr[0] <= w_accept ? a_in[gi] : '0;
                r_b_sr[0] <= w_accept ? b_in[gi] : '0;
                for (int d = 1; d <= gi; d++) begin
                    r_a_sr[d] <= r_a_sr[d-1];
                    r_b_sr[d] <= r_b_sr[d-1];
                end
            end
        end

        assign w_a_feed[gi] = r_a_sr[gi];
        assign w_b_feed[gi] = r_b_sr[gi];
    end

    // ------------------------------------------------------------------
    // PE array: A moves right, B moves down, sums stay in place.
    // ------------------------------------------------------------------
    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] w_a_left;
    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] w_b_top;
    logic [N-1:0][N-2:0][DATA_WIDTH-1:0] r_a_pass;
    logic [N-2:0][N-1:0][DATA_WIDTH-1:0] r_b_pass;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]  r_acc;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]  w_acc_next;

    for (gi = 0; gi < N; gi++) begin : g_row
        for (gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign w_a_left[gi][gj] = w_a_feed[gi];
            end else begin : g_a_inner
                assign w_a_left[gi][gj] = r_a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_top[gi][gj] = w_b_feed[gj];
            end else begin : g_b_inner
                assign w_b_top[gi][gj] = r_b_pass[gi-1][gj];
            end
        end
    end

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_ext;
    logic        [ACC_WIDTH:0]      w_sum;

    always_comb begin
        w_acc_next = r_acc;
        w_prod     = '0;
        w_ext      = '0;
        w_sum      = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_prod = $signed(w_a_left[i][j]) * $signed(w_b_top[i][j]);
                w_ext  = ACC_WIDTH'(w_prod);
                // One guard bit exposes overflow: the two top bits disagree.
                w_sum  = {w_ext[ACC_WIDTH-1], w_ext}
                       + {r_acc[i][j][ACC_WIDTH-1], r_acc[i][j]};
                if ((SATURATE != 0) && (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1])) begin
                    w_acc_next[i][j] = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
                end else begin
                    w_acc_next[i][j] = w_sum[ACC_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_pass <= '0;
            r_b_pass <= '0;
            r_acc    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N-1; j++) begin
                    r_a_pass[i][j] <= w_a_left[i][j];
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_b_pass[i][j] <= w_b_top[i][j];
                end
            end
            // The pipeline is empty whenever start is taken, so clearing
            // here cannot drop a product still in flight.
            if (w_clear) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result drain: one row per transfer, no bubbles between rows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_out   <= '0;
            c_row   <= '0;
            done    <= 1'b0;
        end else begin
            done <= w_last_xfer;
            if (w_load_first) begin
                c_valid <= 1'b1;
                c_row   <= '0;
                c_out   <= r_acc[0];
            end else if (w_last_xfer) begin
                c_valid <= 1'b0;
                c_row   <= '0;
            end else if (w_row_xfer) begin
                c_row   <= w_next_row;
                c_out   <= r_acc[w_next_row];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_mat_mult_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_mat_mult_nxn
// Purpose  : Self-checking bench for systolic_array_mat_mult_nxn. Three
//            instances share all inputs: 32-bit wrap, 16-bit saturating and
//            16-bit wrap. A per-beat arithmetic model predicts every C row.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_mat_mult_nxn;

    localparam int N    = 8;
    localparam int KBUF = 300;

    logic clk = 1'b0;
    logic rst, start, accumulate, a_valid, b_valid, c_ready;
    logic [8:0] k_len;
    logic [N-1:0][7:0] a_in, b_in;

    logic rdy [3];
    logic dn  [3];
    logic ard [3];
    logic brd [3];
    logic cv  [3];
    logic [2:0] crow [3];
    logic [N-1:0][31:0] c0;
    logic [N-1:0][15:0] c1, c2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_mat_mult_nxn u0 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accumulate(accumulate),
        .ready(rdy[0]), .done(dn[0]), .a_valid(a_valid), .a_ready(ard[0]), .a_in(a_in),
        .b_valid(b_valid), .b_ready(brd[0]), .b_in(b_in), .c_valid(cv[0]),
        .c_ready(c_ready), .c_out(c0), .c_row(crow[0]));

    systolic_array_mat_mult_nxn #(.ACC_WIDTH(16), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accumulate(accumulate),
        .ready(rdy[1]), .done(dn[1]), .a_valid(a_valid), .a_ready(ard[1]), .a_in(a_in),
        .b_valid(b_valid), .b_ready(brd[1]), .b_in(b_in), .c_valid(cv[1]),
        .c_ready(c_ready), .c_out(c1), .c_row(crow[1]));

    systolic_array_mat_mult_nxn #(.ACC_WIDTH(16), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accumulate(accumulate),
        .ready(rdy[2]), .done(dn[2]), .a_valid(a_valid), .a_ready(ard[2]), .a_in(a_in),
        .b_valid(b_valid), .b_ready(brd[2]), .b_in(b_in), .c_valid(cv[2]),
        .c_ready(c_ready), .c_out(c2), .c_row(crow[2]));

    int vectors     = 0;
    int miscompares = 0;

    // Operand tables and reference accumulators (0: 32 wrap, 1: 16 sat, 2: 16 wrap)
    int     ta [KBUF][N];
    int     tb [KBUF][N];
    longint m  [3][N][N];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input bit r, input bit d,
                           input bit ab, input bit v);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s_ready%0d", tag, u),   64'(rdy[u]), 64'(r));
            chk($sformatf("%s_done%0d", tag, u),    64'(dn[u]),  64'(d));
            chk($sformatf("%s_a_ready%0d", tag, u), 64'(ard[u]), 64'(ab));
            chk($sformatf("%s_b_ready%0d", tag, u), 64'(brd[u]), 64'(ab));
            chk($sformatf("%s_c_valid%0d", tag, u), 64'(cv[u]),  64'(v));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint x;
        x = v & ((64'sd1 <<< w) - 1);
        if (x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    function automatic longint satw(input longint v, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear;
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) m[u][i][j] = 0;
    endtask

    // One accepted beat adds the outer product A[:,k] * B[k,:].
    task automatic model_beat(input int k);
        longint p;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                p = longint'(ta[k][i]) * longint'(tb[k][j]);
                m[0][i][j] = wrapw(m[0][i][j] + p, 32);
                m[1][i][j] = satw(m[1][i][j] + p, 16);
                m[2][i][j] = wrapw(m[2][i][j] + p, 16);
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int k = 0; k < KBUF; k++)
            for (int i = 0; i < N; i++) begin ta[k][i] = v; tb[k][i] = v; end
    endtask

    task automatic fill_rand;
        for (int k = 0; k < KBUF; k++)
            for (int i = 0; i < N; i++) begin
                ta[k][i] = int'($urandom_range(0, 255)) - 128;
                tb[k][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_ident;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                ta[k][i] = (i == k) ? 1 : 0;
                tb[k][i] = k * 8 + i;
            end
    endtask

    // One complete operation. pv/pr: percent chance of a valid / c_ready.
    // For the first 'hold' LOAD cycles a_valid toggles with b_valid low.
    // start stays high through LOAD and DRAIN, where it must be ignored.
    task automatic run_op(input int k, input bit accu, input int pv,
                          input int pr, input int hold);
        int keff, got, guard, n, row;
        keff = (k > 256) ? 256 : k;
        k_len = 9'(k);
        accumulate = accu;
        start = 1'b1;
        tick;
        if (!accu) model_clear();
        n = cyc;
        chk_ctl("start", 1'b0, 1'b0, keff > 0, 1'b0);
        got = 0;
        guard = 0;
        while (got < keff && guard < 4000) begin
            for (int i = 0; i < N; i++) begin
                a_in[i] = 8'(ta[got][i]);
                b_in[i] = 8'(tb[got][i]);
            end
            if (guard < hold) begin
                a_valid = ((guard % 2) == 0);
                b_valid = 1'b0;
            end else begin
                a_valid = (int'($urandom_range(0, 99)) < pv);
                b_valid = (int'($urandom_range(0, 99)) < pv);
            end
            tick;
            guard++;
            if (a_valid && b_valid) begin
                model_beat(got);
                got++;
                n = cyc;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("beats", 64'(got), 64'(keff));
        chk_ctl("drain", 1'b0, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (cv[0] !== 1'b1 && guard < 64) begin
            tick;
            guard++;
        end
        start = 1'b0;
        chk("latency", 64'(cyc - n), 64'(2 * N + 1));
        row = 0;
        guard = 0;
        while (row < N && guard < 1000) begin
            for (int u = 0; u < 3; u++) begin
                chk($sformatf("row%0d_c_valid%0d", row, u), 64'(cv[u]), 1);
                chk($sformatf("row%0d_c_row%0d", row, u), 64'(crow[u]), 64'(row));
            end
            for (int j = 0; j < N; j++) begin
                chk($sformatf("c32[%0d][%0d]", row, j),  64'($signed(c0[j])), m[0][row][j]);
                chk($sformatf("c16s[%0d][%0d]", row, j), 64'($signed(c1[j])), m[1][row][j]);
                chk($sformatf("c16w[%0d][%0d]", row, j), 64'($signed(c2[j])), m[2][row][j]);
            end
            c_ready = (int'($urandom_range(0, 99)) < pr);
            tick;
            guard++;
            if (c_ready) row++;
        end
        c_ready = 1'b0;
        chk("rows_out", 64'(row), 64'(N));
        chk_ctl("done", 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        chk_ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; accumulate = 1'b0; k_len = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0;
        a_in = '0; b_in = '0;
        model_clear();

        // Reset state
        tick; tick;
        chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_c32", 64'(|c0), 0);
        chk("reset_c16s", 64'(|c1), 0);
        chk("reset_c16w", 64'(|c2), 0);
        for (int u = 0; u < 3; u++) chk($sformatf("reset_c_row%0d", u), 64'(crow[u]), 0);
        rst = 1'b0;
        tick;

        // Identity A: rows of C reproduce B
        fill_ident();
        run_op(8, 1'b0, 100, 100, 0);

        // Most negative operands everywhere
        fill_const(-128);
        run_op(8, 1'b0, 100, 100, 0);

        // Tiling: 4 + 4 with accumulate, then a fresh 4
        fill_const(1);
        run_op(4, 1'b0, 100, 100, 0);
        run_op(4, 1'b1, 100, 100, 0);
        run_op(4, 1'b0, 100, 100, 0);

        // 127*127 over 3 beats: saturates at 16 bits, wraps otherwise
        fill_const(127);
        run_op(3, 1'b0, 100, 100, 0);

        // Lone a_valid, then random valids and output backpressure
        fill_rand();
        run_op(5, 1'b0, 80, 50, 6);
        fill_rand();
        run_op(6, 1'b1, 70, 40, 0);

        // Reset after 3 beats of an 8-beat load
        fill_const(1);
        k_len = 9'd8; accumulate = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < N; i++) begin a_in[i] = 8'd1; b_in[i] = 8'd1; end
        tick; tick; tick;
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_clear();
        chk_ctl("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(1, 1'b1, 100, 100, 0);

        // k_len = 0 re-presents the accumulators untouched
        run_op(0, 1'b1, 100, 60, 0);

        // k_len beyond K_MAX clamps to K_MAX
        fill_const(1);
        run_op(300, 1'b0, 100, 100, 0);

        // Longer random operation with sparse handshakes
        fill_rand();
        run_op(20, 1'b0, 60, 60, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
